// File: rtl/ot_pkg.sv
// Shared definitions for the OT sender: word geometry, FSM encodings and the
// link byte order that sender and receiver must agree on.
package ot_pkg;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BYTES     = WORD_W / 8;
  localparam int unsigned PUB_WORDS = 4;
  localparam int unsigned MSG_WORDS = 2;
  localparam bit          LSB_FIRST = 1'b1;

  typedef enum logic [2:0] {IDLE, TX_PUB, RX_V, EXP0, EXP1, ADD, TX_MSG, DONE} state_t;
  typedef enum logic [2:0] {M_IDLE, M_CHECK, M_MUL, M_UPDATE, M_END} exp_state_t;

  // Bit-lane of the idx-th byte on the link within a word of nbytes bytes.
  function automatic int unsigned byte_lane(input int unsigned idx, input int unsigned nbytes);
    return LSB_FIRST ? idx : nbytes - 1 - idx;
  endfunction
endpackage

// File: rtl/sender_mod_exp.sv
// Modular exponentiation res = base^d mod n, right-to-left square-and-multiply.
// Both products of one exponent bit (r*b and b*b) share a single shift-add pass over b.
module sender_mod_exp #(
  parameter int unsigned WORD_W = ot_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] base,
  input  logic [WORD_W-1:0] d,
  input  logic [WORD_W-1:0] n,
  input  logic              gen,
  output logic [WORD_W-1:0] res,
  output logic              gen_end
);
  import ot_pkg::*;

  localparam int unsigned CNT_W = $clog2(WORD_W);

  exp_state_t        mst;
  logic [WORD_W-1:0] r, b, e, nn, mult, acc_r, acc_b;
  logic [CNT_W-1:0]  cnt;

  // One interleaved step: acc = (2*acc + sel*a) mod m, assuming acc, a < m.
  function automatic logic [WORD_W-1:0] mul_step(input logic [WORD_W-1:0] acc, a,
                                                 input logic sel,
                                                 input logic [WORD_W-1:0] m);
    logic [WORD_W:0] t;
    t = {acc, 1'b0};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    if (sel) begin
      t = t + {1'b0, a};
      if (t >= {1'b0, m}) t = t - {1'b0, m};
    end
    return t[WORD_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      mst     <= M_IDLE;
      gen_end <= 1'b0;
    end else begin
      case (mst)
        M_IDLE: if (gen) begin
          r   <= WORD_W'(1);
          b   <= base;
          e   <= d;
          nn  <= n;
          mst <= M_CHECK;
        end
        M_CHECK: begin
          // Stops as soon as no set exponent bits remain, so d=0 yields 1.
          if (e == '0) begin
            gen_end <= 1'b1;
            mst     <= M_END;
          end else begin
            acc_r <= '0;
            acc_b <= '0;
            mult  <= b;
            cnt   <= '0;
            mst   <= M_MUL;
          end
        end
        M_MUL: begin
          acc_r <= mul_step(acc_r, r, mult[WORD_W-1], nn);
          acc_b <= mul_step(acc_b, b, mult[WORD_W-1], nn);
          mult  <= mult << 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(WORD_W - 1)) mst <= M_UPDATE;
        end
        M_UPDATE: begin
          if (e[0]) r <= acc_r;
          b   <= acc_b;
          e   <= e >> 1;
          mst <= M_CHECK;
        end
        default: if (!gen) begin
          gen_end <= 1'b0;
          mst     <= M_IDLE;
        end
      endcase
    end
  end

  assign res = r;
endmodule

// File: rtl/ot_sender.sv
// Sender side of 1-out-of-2 oblivious transfer: publishes N, e, x0, x1, takes the
// blinded v, and returns (m0 + (v-x0)^d) mod N and (m1 + (v-x1)^d) mod N.
module ot_sender #(
  parameter int unsigned WORD_W = ot_pkg::WORD_W,
  parameter int unsigned BYTES  = WORD_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] n_key,
  input  logic [WORD_W-1:0] e_key,
  input  logic [WORD_W-1:0] d_key,
  input  logic [WORD_W-1:0] x0_in,
  input  logic [WORD_W-1:0] x1_in,
  input  logic [WORD_W-1:0] m0_in,
  input  logic [WORD_W-1:0] m1_in,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [7:0]        rx_data,
  output logic              busy,
  output logic              done
);
  import ot_pkg::*;

  localparam int unsigned LANE_W = $clog2(BYTES);
  localparam int unsigned WSEL_W = $clog2(PUB_WORDS);

  state_t            state;
  logic [WORD_W-1:0] n_r, e_r, d_r, x0_r, x1_r, m0_r, m1_r, v_r;
  logic [WORD_W-1:0] base_r, k0_r, k1_r, mp0_r, mp1_r;
  logic [LANE_W-1:0] lane, lane_nxt;
  logic [WSEL_W-1:0] word, word_nxt;
  logic              last_lane, gen, exp_end;
  logic [WORD_W-1:0] pub_word, msg_word, exp_base, exp_res, sum0, sum1;

  function automatic logic [7:0] pick(input logic [WORD_W-1:0] w, input logic [LANE_W-1:0] l);
    return w[8*byte_lane(32'(l), BYTES) +: 8];
  endfunction

  function automatic logic [WORD_W-1:0] mod_add(input logic [WORD_W-1:0] a, b, m);
    logic [WORD_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[WORD_W-1:0];
  endfunction

  // Borrow out of the 33-bit difference means a < b, so wrap by adding m.
  function automatic logic [WORD_W-1:0] mod_sub(input logic [WORD_W-1:0] a, b, m);
    logic [WORD_W:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (s[WORD_W]) s = s + {1'b0, m};
    return s[WORD_W-1:0];
  endfunction

  always_comb begin
    last_lane = (lane == LANE_W'(BYTES - 1));
    lane_nxt  = last_lane ? '0 : lane + 1'b1;
    word_nxt  = last_lane ? word + 1'b1 : word;
    case (word_nxt)
      WSEL_W'(0): pub_word = n_r;
      WSEL_W'(1): pub_word = e_r;
      WSEL_W'(2): pub_word = x0_r;
      default:    pub_word = x1_r;
    endcase
    msg_word = (word_nxt == '0) ? mp0_r : mp1_r;
    exp_base = mod_sub(v_r, (state == EXP1) ? x1_r : x0_r, n_r);
    sum0     = mod_add(m0_r, k0_r, n_r);
    sum1     = mod_add(m1_r, k1_r, n_r);
  end

  sender_mod_exp #(.WORD_W(WORD_W)) u_exp (
    .clk     (clk),
    .reset   (reset),
    .base    (base_r),
    .d       (d_r),
    .n       (n_r),
    .gen     (gen),
    .res     (exp_res),
    .gen_end (exp_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      rx_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      gen      <= 1'b0;
      lane     <= '0;
      word     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          n_r  <= n_key;  e_r  <= e_key;  d_r  <= d_key;
          x0_r <= x0_in;  x1_r <= x1_in;
          m0_r <= m0_in;  m1_r <= m1_in;
          busy     <= 1'b1;
          tx_valid <= 1'b1;
          tx_data  <= pick(n_key, '0);
          lane     <= '0;
          word     <= '0;
          state    <= TX_PUB;
        end
        TX_PUB: if (tx_valid && tx_ready) begin
          if (last_lane && word == WSEL_W'(PUB_WORDS - 1)) begin
            tx_valid <= 1'b0;
            rx_ready <= 1'b1;
            lane     <= '0;
            word     <= '0;
            state    <= RX_V;
          end else begin
            lane    <= lane_nxt;
            word    <= word_nxt;
            tx_data <= pick(pub_word, lane_nxt);
          end
        end
        RX_V: if (rx_valid) begin
          v_r[8*byte_lane(32'(lane), BYTES) +: 8] <= rx_data;
          lane <= lane_nxt;
          if (last_lane) begin
            rx_ready <= 1'b0;
            state    <= EXP0;
          end
        end
        EXP0, EXP1: begin
          // gen is low on entry to each exponent state, which launches the engine once.
          if (!gen) begin
            base_r <= exp_base;
            gen    <= 1'b1;
          end else if (exp_end) begin
            gen <= 1'b0;
            if (state == EXP0) begin
              k0_r  <= exp_res;
              state <= EXP1;
            end else begin
              k1_r  <= exp_res;
              state <= ADD;
            end
          end
        end
        ADD: begin
          mp0_r    <= sum0;
          mp1_r    <= sum1;
          tx_valid <= 1'b1;
          tx_data  <= pick(sum0, '0);
          lane     <= '0;
          word     <= '0;
          state    <= TX_MSG;
        end
        TX_MSG: if (tx_valid && tx_ready) begin
          if (last_lane && word == WSEL_W'(MSG_WORDS - 1)) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            lane    <= lane_nxt;
            word    <= word_nxt;
            tx_data <= pick(msg_word, lane_nxt);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ot_sender.sv
// Directed bench for ot_sender: drives the byte link as the OT receiver and
// checks published parameters and returned blinded messages against hand values.
module tb_ot_sender;
  logic        clk = 1'b0;
  logic        reset, start, tx_ready, rx_valid;
  logic [31:0] n_key, e_key, d_key, x0_in, x1_in, m0_in, m1_in;
  logic        tx_valid, rx_ready, busy, done;
  logic [7:0]  tx_data, rx_data;

  int   checks = 0;
  int   errors = 0;
  bit   bp = 1'b0;
  logic [7:0] txq [$];

  ot_sender dut (
    .clk(clk), .reset(reset), .start(start),
    .n_key(n_key), .e_key(e_key), .d_key(d_key),
    .x0_in(x0_in), .x1_in(x1_in), .m0_in(m0_in), .m1_in(m1_in),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic abort(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed no progress within cycle budget, expected DUT response", tag);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "stopping after timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 32'({tx_valid, tx_data, rx_ready, busy, done}), 32'h0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_outputs");
    reset = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] n, e, d, x0, x1, m0, m1);
    txq.delete();
    @(negedge clk);
    tx_ready = 1'b0;
    n_key = n; e_key = e; d_key = d; x0_in = x0; x1_in = x1; m0_in = m0; m1_in = m1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_key = $urandom; e_key = $urandom; d_key = $urandom;
    x0_in = $urandom; x1_in = $urandom; m0_in = $urandom; m1_in = $urandom;
    check("busy_after_start", 32'(busy), 32'h1);
  endtask

  // Accepts count bytes, checking tx_data/tx_valid hold during every stall.
  task automatic recv_bytes(input int count, input int budget);
    logic [7:0] held;
    bit         stall;
    int         t;
    for (int i = 0; i < count; i++) begin
      t = 0; stall = 1'b0; held = '0;
      forever begin
        @(negedge clk);
        if (stall) check("tx_hold", 32'({tx_valid, tx_data}), 32'({1'b1, held}));
        if (t >= budget) abort("tx_timeout");
        t++;
        tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (tx_valid && tx_ready) begin
          txq.push_back(tx_data);
          break;
        end
        stall = tx_valid;
        held  = tx_data;
      end
    end
    @(posedge clk);
    #1 tx_ready = 1'b0;
  endtask

  function automatic logic [31:0] pop_word();
    logic [31:0] w;
    for (int unsigned k = 0; k < 4; k++) w[8*k +: 8] = txq.pop_front();
    return w;
  endfunction

  task automatic send_v(input logic [31:0] v);
    int t = 0;
    int gap;
    @(negedge clk);
    while (rx_ready !== 1'b1) begin
      if (t >= 50) abort("rx_ready_timeout");
      t++;
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      gap = bp ? int'($urandom_range(1, 5)) : 1;
      repeat (gap - 1) @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = v[8*k +: 8];
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h5A;
    end
    check("rx_ready_drop", 32'(rx_ready), 32'h0);
  endtask

  task automatic check_pub(input string tag, input logic [31:0] n, e, x0, x1);
    check({tag, "_N"},  pop_word(), n);
    check({tag, "_e"},  pop_word(), e);
    check({tag, "_x0"}, pop_word(), x0);
    check({tag, "_x1"}, pop_word(), x1);
  endtask

  task automatic finish_msg(input string tag, input logic [31:0] mp0, mp1);
    recv_bytes(8, 5000);
    check({tag, "_m0p"}, pop_word(), mp0);
    check({tag, "_m1p"}, pop_word(), mp1);
    @(negedge clk);
    check({tag, "_done_busy_txv"}, 32'({done, busy, tx_valid}), 32'b100);
  endtask

  task automatic run_transfer(input string tag, input logic [31:0] d, m0, v, mp0, mp1);
    do_start(32'd33, 32'd3, d, 32'd5, 32'd10, m0, 32'd20);
    recv_bytes(16, 20);
    check_pub(tag, 32'h21, 32'h03, 32'h05, 32'h0A);
    send_v(v);
    finish_msg(tag, mp0, mp1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    n_key = '0; e_key = '0; d_key = '0; x0_in = '0; x1_in = '0; m0_in = '0; m1_in = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("initial_reset");
    reset = 1'b0;

    // k0=1, k1=17: m0'=8, m1'=(20+17)-33=4
    run_transfer("nominal", 32'd7, 32'd7, 32'd6, 32'h08, 32'h04);

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("start_in_done", 32'({done, busy, tx_valid}), 32'b100);

    // k0=5^7 mod 33=14, k1=0
    apply_reset();
    run_transfer("v_eq_x1", 32'd7, 32'd7, 32'd10, 32'h15, 32'h14);

    apply_reset();
    bp = 1'b1;
    run_transfer("backpressure", 32'd7, 32'd7, 32'd6, 32'h08, 32'h04);
    bp = 1'b0;

    // d=0: k=1, m0'=(32+1) mod 33=0, m1'=21
    apply_reset();
    run_transfer("d_zero", 32'd0, 32'd32, 32'd6, 32'h00, 32'h15);

    // base0=0 -> k0=0; base1=28 -> k1=19, m1'=39-33=6
    apply_reset();
    run_transfer("v_eq_x0", 32'd7, 32'd7, 32'd5, 32'h07, 32'h06);

    apply_reset();
    do_start(32'd33, 32'd3, 32'd7, 32'd5, 32'd10, 32'd7, 32'd20);
    recv_bytes(2, 20);
    @(negedge clk);
    start = 1'b1; n_key = 32'd99; d_key = 32'd1; m0_in = 32'd1;
    rx_valid = 1'b1; rx_data = 8'hAA;
    check("rx_ready_in_tx_pub", 32'(rx_ready), 32'h0);
    @(negedge clk);
    start = 1'b0; rx_valid = 1'b0;
    recv_bytes(14, 20);
    check_pub("control", 32'h21, 32'h03, 32'h05, 32'h0A);
    send_v(32'd6);
    finish_msg("control", 32'h08, 32'h04);

    // All-ones exponent keeps each engine run near its full length.
    apply_reset();
    do_start(32'd33, 32'd3, 32'hFFFF_FFFF, 32'd5, 32'd10, 32'd7, 32'd20);
    recv_bytes(16, 20);
    send_v(32'd6);
    repeat (1500) @(negedge clk);
    check("busy_in_exp1", 32'({busy, tx_valid, done}), 32'b100);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid_exp1");
    reset = 1'b0;
    run_transfer("after_reset_exp1", 32'd7, 32'd7, 32'd6, 32'h08, 32'h04);

    apply_reset();
    do_start(32'd33, 32'd3, 32'd7, 32'd5, 32'd10, 32'd7, 32'd20);
    recv_bytes(16, 20);
    send_v(32'd6);
    recv_bytes(3, 5000);
    @(negedge clk);
    check("tx_msg_pending", 32'({tx_valid, busy, tx_data}), 32'({2'b11, 8'h00}));
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid_tx_msg");
    reset = 1'b0;
    run_transfer("after_reset_tx", 32'd7, 32'd7, 32'd6, 32'h08, 32'h04);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ot_sender.md
Name: ot_sender

Overview:
- Sender side of the 1-out-of-2 oblivious transfer protocol. Transfers its two secret 32-bit messages m0/m1 over an 8-bit byte-stream link.
- Sends the public parameters N, e, x0 and x1, then receives the blinded value v.
- Computes k0 = (v-x0)^d mod N and k1 = (v-x1)^d mod N.
- Returns m0' = (m0+k0) mod N and m1' = (m1+k1) mod N. The peer can recover only one of the two messages.

Parameters:
- WORD_W, 32, width of every protocol variable (must be a multiple of 8).
- BYTES, WORD_W/8, bytes per variable on the link.

Ports:
- clk  in  1  clock.
- reset  in  1  reset (reset reset, synchronous, active-high; clock clk).
- start  in  1  one-cycle pulse that begins a transfer; ignored unless in IDLE.
- n_key  in  32  RSA modulus N; must be >= 2.
- e_key  in  32  public exponent.
- d_key  in  32  private exponent.
- x0_in, x1_in  in  32 each  random values, each < N.
- m0_in, m1_in  in  32 each  secret messages, each < N.
- tx_valid  out  1  byte offered to the peer.
- tx_ready  in  1  peer accepts the byte.
- tx_data  out  8  outgoing byte.
- rx_valid  in  1  peer offers a byte.
- rx_ready  out  1  sender accepts a byte.
- rx_data  in  8  incoming byte.
- busy  out  1  high from start acceptance until DONE.
- done  out  1  high in DONE; sticky until reset.

Behaviour:
- Reset values: tx_valid=0, tx_data=0, rx_ready=0, busy=0, done=0, state=IDLE. The exponent engine is aborted. Reset mid-operation returns to IDLE from any state.
- Link handshake: a byte transfers at a posedge where valid&&ready.
  - tx_data/tx_valid are held stable until accepted.
  - rx_ready is held continuously high in RX_V, so single-cycle rx_valid pulses are caught.
  - rx_valid outside RX_V is ignored.
- Byte order: every variable is sent LSB byte first.
- IDLE:
  - start=1 -> latch all inputs into internal registers, busy<=1, go to TX_PUB.
  - Input changes after the latch have no effect.
- TX_PUB: send 16 bytes in the order N, e, x0, x1. After the last accepted byte: tx_valid<=0, rx_ready<=1, go to RX_V.
- RX_V:
  - Collect 4 bytes into v.
  - On the 4th accepted byte: rx_ready<=0 and the same cycle go to EXP0.
- EXP0:
  - base = (v>=x0) ? v-x0 : v-x0+N, using 33-bit intermediate.
  - Pulse gen to the exponent engine; wait for gen_end; store k0.
- EXP1: same as EXP0 with x1; store k1.
- ADD:
  - m0' = m0+k0, minus N if the sum >= N; same for m1'. Use 33-bit sums.
  - Takes one cycle, then go to TX_MSG.
- TX_MSG: send 8 bytes in the order m0', m1'. After the last accepted byte: tx_valid<=0, go to DONE.
- DONE: done=1, busy=0. Stays in DONE until reset; start is ignored.
- Exponent edge cases:
  - d=0 gives k=1, including base 0.
  - base 0 with d>0 gives k=0.
- Inputs violating the range rules (v >= N, inputs >= N, N<2) give unspecified k values, but the FSM must still complete and reach DONE.
- Latency:
  - Link phases are 1 byte/cycle under full readiness.
  - Each exponentiation finishes in at most 32*2*33 cycles. Exact count is not checked; the bench keys on gen_end and done.

Decomposition:
- Shared package ot_pkg holds:
  - State encodings: IDLE, TX_PUB, RX_V, EXP0, EXP1, ADD, TX_MSG, DONE.
  - WORD_W and BYTES.
  - Byte-order constants, so the sender and receiver agree on LSB-first order.
- One sub-module, sender_mod_exp: (base, d, N, gen) -> (res, gen_end).
  - Right-to-left square-and-multiply.
  - Each modular multiply is an interleaved shift-add (32 iterations, conditional subtract of N), with no divider.
  - gen_end is held high while gen stays high; the parent deasserts gen after capturing res.

Test Plan:
- Nominal transfer. N=33, e=3, d=7, x0=5, x1=10, m0=7, m1=20, start, tx_ready=1.
  - Expected TX bytes: 21 00 00 00, 03 00 00 00, 05 00 00 00, 0A 00 00 00.
  - Then feed v=6 (06 00 00 00). Expected k0=1, k1=17, and TX bytes 08 00 00 00, 04 00 00 00.
  - done=1 afterwards.
- v=x1. Same keys, v=10.
  - Expected k0=14, k1=0, and TX m0'=21 (15 00 00 00), m1'=20 (14 00 00 00).
- Backpressure. tx_ready toggles pseudo-randomly and the rx_valid byte-pulse spacing varies from 1 to 5 cycles.
  - Expected: the identical 24-byte TX sequence, each byte sent exactly once, tx_data stable while tx_valid && !tx_ready.
- Exponent edges. d=0 gives m0'=m0+1 mod N. With v=x0 and d=7, k0=0 and m0'=m0.
- Control.
  - start pulsed during TX_PUB or DONE is ignored.
  - rx_valid during TX_PUB is ignored, with rx_ready=0.
  - Inputs changed after start have no effect on the output bytes.
- Reset mid-EXP1 and mid-TX_MSG.
  - Expected next cycle: all outputs at reset values.
  - A fresh start repeats scenario 1 exactly.
